// File: rtl/isbox_pkg.sv
// rtl/isbox_pkg.sv - shared defaults, FSM encoding and AES byte tables for the S-box engine
package isbox_pkg;

   localparam int ROWS_DEF   = 16;
   localparam int COLS_DEF   = 16;
   localparam int CHAR_W_DEF = 16;
   localparam int LANES_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/isbox_lut.sv
// rtl/isbox_lut.sv - single-byte AES S-box / inverse S-box lookup (mode 1 = forward)
module isbox_lut
   import isbox_pkg::*;
(
   input  logic       mode,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = mode ? SBOX[din] : INV_SBOX[din];

endmodule

// File: rtl/isbox_engine.sv
// rtl/isbox_engine.sv - walks a captured character matrix, substituting LANES chars per cycle on masked rows
module isbox_engine
   import isbox_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int CHAR_W = CHAR_W_DEF,
   parameter int LANES  = LANES_DEF
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   mode,
   input  logic [ROWS-1:0]                        ip_row_mask,
   input  logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0]  ip_char_matrix,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   op_char_matrix_valid,
   output logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0]  op_char_matrix
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   generate
      if ((COLS % LANES) != 0) begin : g_bad_lanes
         $error("isbox_engine: COLS must be a multiple of LANES");
      end
      if (CHAR_W < 8) begin : g_bad_width
         $error("isbox_engine: CHAR_W must be at least 8");
      end
   endgenerate

   typedef logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0] matrix_t;

   state_t                  state, state_nxt;
   logic [RW-1:0]           row_q;
   logic [CW-1:0]           col_q;
   logic                    mode_q;
   logic [ROWS-1:0]         mask_q;
   matrix_t                 mat_q, out_q;
   logic                    valid_q, done_q, done_set;
   logic                    accept, row_end, run_last;
   logic [LANES-1:0][7:0]   lut_in, lut_out;

   // done is registered one cycle behind DONE, so a start seen alongside it is still refused
   assign accept   = (state == ST_IDLE) && start && !done_q;
   assign row_end  = !mask_q[row_q] || (col_q == CW'(COLS - LANES));
   assign run_last = (row_q == RW'(ROWS - 1)) && row_end;

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign lut_in[l] = mat_q[row_q][col_q + CW'(l)][7:0];
         isbox_lut u_lut (
            .mode (mode_q),
            .din  (lut_in[l]),
            .dout (lut_out[l])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)   state_nxt = ST_RUN;
         ST_RUN:  if (run_last) state_nxt = ST_DONE;
         ST_DONE:               state_nxt = ST_IDLE;
         default:               state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b1;
      done_set = 1'b0;
      case (state)
         ST_IDLE: busy     = 1'b0;
         ST_DONE: done_set = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q   <= '0;
         col_q   <= '0;
         mode_q  <= 1'b0;
         mask_q  <= '0;
         mat_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= done_set;
         if (done_set) valid_q <= 1'b1;
         if (accept) begin
            mode_q  <= mode;
            mask_q  <= ip_row_mask;
            mat_q   <= ip_char_matrix;
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
         end else if (state == ST_RUN) begin
            if (mask_q[row_q]) begin
               for (int l = 0; l < LANES; l++) begin
                  out_q[row_q][col_q + CW'(l)] <= CHAR_W'(lut_out[l]);
               end
               col_q <= row_end ? '0 : col_q + CW'(LANES);
            end else begin
               out_q[row_q] <= mat_q[row_q];
            end
            if (row_end) row_q <= run_last ? '0 : row_q + RW'(1);
         end
      end
   end

   assign done                 = done_q;
   assign op_char_matrix_valid = valid_q;
   assign op_char_matrix       = out_q;

endmodule

// File: tb/tb_isbox_engine.sv
// tb/tb_isbox_engine.sv - scoreboard bench for isbox_engine with an independently derived AES S-box model
module tb_isbox_engine;

   localparam int ROWS   = 16;
   localparam int COLS   = 16;
   localparam int CHAR_W = 16;
   localparam int LANES  = 4;

   typedef logic [ROWS-1:0][COLS-1:0][CHAR_W-1:0] mat_t;

   logic            clk = 1'b0;
   logic            reset, start, mode;
   logic [ROWS-1:0] ip_row_mask;
   mat_t            ip_char_matrix, op_char_matrix;
   logic            busy, done, op_char_matrix_valid;

   int        n_checks = 0;
   int        n_errors = 0;
   logic [7:0] fwd_tbl [256];
   logic [7:0] inv_tbl [256];
   mat_t      exp_q [$];

   always #5 clk = ~clk;

   isbox_engine #(.ROWS(ROWS), .COLS(COLS), .CHAR_W(CHAR_W), .LANES(LANES)) dut (
      .clk                  (clk),
      .reset                (reset),
      .start                (start),
      .mode                 (mode),
      .ip_row_mask          (ip_row_mask),
      .ip_char_matrix       (ip_char_matrix),
      .busy                 (busy),
      .done                 (done),
      .op_char_matrix_valid (op_char_matrix_valid),
      .op_char_matrix       (op_char_matrix)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   // GF(2^8) inverse followed by the AES affine map
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b, s;
         b = 8'h00;
         for (int y = 1; y < 256 && b == 8'h00 && x != 0; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
         fwd_tbl[x] = s;
         inv_tbl[s] = 8'(x);
      end
   endtask

   function automatic mat_t model(input logic m, input logic [ROWS-1:0] mask, input mat_t src);
      mat_t r;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            r[i][j] = mask[i] ? CHAR_W'(m ? fwd_tbl[src[i][j][7:0]] : inv_tbl[src[i][j][7:0]]) : src[i][j];
      return r;
   endfunction

   function automatic int latency(input logic [ROWS-1:0] mask);
      int n = 0;
      for (int i = 0; i < ROWS; i++) n += mask[i] ? COLS / LANES : 1;
      return n + 1;
   endfunction

   function automatic mat_t rand_mat();
      mat_t r;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) r[i][j] = CHAR_W'($urandom);
      return r;
   endfunction

   function automatic mat_t ramp_mat();
      mat_t r;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) r[i][j] = CHAR_W'(10 * i + j);
      return r;
   endfunction

   task automatic launch(input logic m, input logic [ROWS-1:0] mask, input mat_t src);
      mode = m; ip_row_mask = mask; ip_char_matrix = src; start = 1'b1;
      exp_q.push_back(model(m, mask, src));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input bit disturb, output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 300) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 1) check("busy_run", busy, 1);
         if (disturb && edges == 5) begin
            start = 1'b1; mode = ~mode; ip_row_mask = ~ip_row_mask; ip_char_matrix = rand_mat();
         end
         if (disturb && edges == 7) start = 1'b0;
      end
      check("done_seen", done, 1);
   endtask

   task automatic compare_result(input string tag);
      mat_t e;
      e = exp_q.pop_front();
      for (int r = 0; r < ROWS; r++)
         check($sformatf("%s_row%0d", tag, r), op_char_matrix[r], e[r]);
   endtask

   task automatic finish_job(input string tag, input int edges, input int exp_edges);
      check({tag, "_latency"}, edges, exp_edges);
      check({tag, "_valid"}, op_char_matrix_valid, 1);
      compare_result(tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      mat_t m0, m1;
      int   e;
      build_tables();
      reset = 1'b1; start = 1'b0; mode = 1'b0; ip_row_mask = '0; ip_char_matrix = '0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", op_char_matrix_valid, 0);
      check("rst_out", |op_char_matrix, 0);
      reset = 1'b0;

      launch(1'b0, 16'hFFFF, ramp_mat());
      wait_done(1'b0, e);
      check("inv_00", op_char_matrix[0][0], 16'h0052);
      check("inv_01", op_char_matrix[0][1], 16'h0009);
      finish_job("inv_all", e, 65);

      launch(1'b0, 16'h0001, ramp_mat());
      wait_done(1'b0, e);
      check("pass_10", op_char_matrix[1][0], 16'h000A);
      finish_job("row0", e, 20);

      m0 = rand_mat();
      m0[0][0] = 16'h0000; m0[0][1] = 16'h0001; m0[0][2] = 16'hAB52;
      launch(1'b1, 16'hFFFF, m0);
      wait_done(1'b0, e);
      check("fwd_00", op_char_matrix[0][0], 16'h0063);
      check("fwd_01", op_char_matrix[0][1], 16'h007C);
      check("fwd_02", op_char_matrix[0][2], 16'h0000);
      finish_job("fwd", e, 65);

      m0 = rand_mat();
      launch(1'b0, 16'h0000, m0);
      wait_done(1'b0, e);
      check("nomask_eq", op_char_matrix[5], m0[5]);
      finish_job("nomask", e, 17);
      repeat (5) @(negedge clk);
      check("valid_hold", op_char_matrix_valid, 1);

      m1 = rand_mat();
      launch(1'b1, 16'hA5C3, m1);
      check("valid_clr", op_char_matrix_valid, 0);
      wait_done(1'b1, e);
      finish_job("disturb", e, latency(16'hA5C3));

      launch(1'b0, 16'h0000, rand_mat());
      wait_done(1'b0, e);
      check("pre_latency", e, 17);
      m1 = rand_mat();
      mode = 1'b1; ip_row_mask = 16'h8001; ip_char_matrix = m1; start = 1'b1;
      @(negedge clk);
      check("ign_done_busy", busy, 0);
      compare_result("pre_restart");
      exp_q.push_back(model(1'b1, 16'h8001, m1));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", busy, 1);
      wait_done(1'b0, e);
      finish_job("restart", e, latency(16'h8001));

      launch(1'b0, 16'hFFFF, rand_mat());
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_valid", op_char_matrix_valid, 0);
      check("mid_rst_out", |op_char_matrix, 0);
      m0 = exp_q.pop_front();
      @(negedge clk);
      reset = 1'b0;
      launch(1'b1, 16'h00F0, rand_mat());
      wait_done(1'b0, e);
      finish_job("post_rst", e, latency(16'h00F0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
